// File: rtl/sm_fv_stream_rx.sv
// Small-FV side receiver for the Big-FV stream: captures each sos..eos burst into one
// half of a ping-pong line buffer addressed by A, then exposes it for 1-cycle random reads.
module sm_fv_stream_rx #(
  parameter int FV_BW  = 64,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int CNT_W  = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_sos,
  input  logic              in_eos,
  input  logic [ADDR_W+1:0] in_A,
  input  logic [FV_BW-1:0]  in_FV_data,
  output logic              rx_ready,
  output logic              buf_valid,
  output logic [CNT_W-1:0]  buf_lines,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [FV_BW-1:0]  rd_data,
  input  logic              rd_done,
  output logic              ovf_err,
  output logic              proto_err
);

  typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t             state;
  logic [1:0]         full;
  logic [CNT_W-1:0]   cnt [2];
  logic               wr_ptr;
  logic               rd_ptr;
  logic [FV_BW-1:0]   mem [2*DEPTH];

  logic [ADDR_W-1:0]  wr_addr;
  logic               wr_beat;
  logic               release_half;
  logic               unused_a_hi;

  assign wr_addr     = in_A[ADDR_W-1:0];
  assign unused_a_hi = ^in_A[ADDR_W+1:ADDR_W];

  // A beat is written either when a stream opens into a free half or on any cycle mid-stream.
  assign wr_beat = ((state == IDLE) && in_sos && !full[wr_ptr]) || (state == RECV);
  assign release_half = rd_done && full[rd_ptr];

  assign rx_ready  = !full[wr_ptr] && (state == IDLE);
  assign buf_valid = full[rd_ptr];
  assign buf_lines = cnt[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_beat)
      mem[{wr_ptr, wr_addr}] <= in_FV_data;
  end

  // The write side only touches a half that is not full, and release only touches a full
  // half, so both sides can update in the same cycle without colliding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      full      <= 2'b00;
      cnt[0]    <= '0;
      cnt[1]    <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      rd_data   <= '0;
      ovf_err   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (rd_en && full[rd_ptr])
        rd_data <= mem[{rd_ptr, rd_addr}];

      if (release_half) begin
        full[rd_ptr] <= 1'b0;
        cnt[rd_ptr]  <= '0;
        rd_ptr       <= ~rd_ptr;
      end

      case (state)
        IDLE: begin
          if (in_sos) begin
            if (!full[wr_ptr]) begin
              cnt[wr_ptr] <= CNT_ONE;
              if (in_eos) begin
                full[wr_ptr] <= 1'b1;
                wr_ptr       <= ~wr_ptr;
              end else begin
                state <= RECV;
              end
            end else begin
              ovf_err <= 1'b1;
              if (!in_eos)
                state <= DROP;
            end
          end
        end
        RECV: begin
          // A repeated sos restarts the capture with the current beat as line one.
          if (in_sos) begin
            proto_err   <= 1'b1;
            cnt[wr_ptr] <= CNT_ONE;
          end else if (cnt[wr_ptr] != CNT_MAX) begin
            cnt[wr_ptr] <= cnt[wr_ptr] + 1'b1;
          end
          if (in_eos) begin
            full[wr_ptr] <= 1'b1;
            wr_ptr       <= ~wr_ptr;
            state        <= IDLE;
          end
        end
        DROP: begin
          if (in_eos)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sm_fv_stream_rx.sv
// Self-checking bench for sm_fv_stream_rx: scripted streams, a table of reads and a
// scoreboard queue holding expected read data until rd_data is sampled.
module tb_sm_fv_stream_rx;

  logic        clk;
  logic        reset;
  logic        in_sos;
  logic        in_eos;
  logic [9:0]  in_A;
  logic [63:0] in_FV_data;
  logic        rx_ready;
  logic        buf_valid;
  logic [8:0]  buf_lines;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic [63:0] rd_data;
  logic        rd_done;
  logic        ovf_err;
  logic        proto_err;

  int tests_run;
  int tests_failed;
  logic [63:0] exp_q[$];

  typedef struct {
    logic [7:0]  addr;
    logic [63:0] data;
  } rd_vec_t;

  rd_vec_t vecs[6];

  sm_fv_stream_rx dut (
    .clk(clk), .reset(reset), .in_sos(in_sos), .in_eos(in_eos), .in_A(in_A),
    .in_FV_data(in_FV_data), .rx_ready(rx_ready), .buf_valid(buf_valid),
    .buf_lines(buf_lines), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_done(rd_done), .ovf_err(ovf_err), .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] beat_data(int seed, int i);
    logic [15:0] s;
    logic [15:0] b;
    s = seed[15:0];
    b = i[15:0];
    return {16'hFEED, s, 16'h0000, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(string name, logic [63:0] act, logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(logic sos, logic eos, logic [9:0] a, logic [63:0] d, logic done);
    in_sos     = sos;
    in_eos     = eos;
    in_A       = a;
    in_FV_data = d;
    rd_done    = done;
    tick();
    in_sos  = 1'b0;
    in_eos  = 1'b0;
    rd_done = 1'b0;
  endtask

  // Upper A bits are deliberately non-zero to confirm they are ignored.
  task automatic send_beats(int base, int n, int seed, bit first_sos, bit last_eos, bit done_on_last);
    for (int i = 0; i < n; i++) begin
      apply_stimulus(first_sos && (i == 0), last_eos && (i == n - 1),
                     10'((i % 4) << 8) | 10'(base + i), beat_data(seed, i),
                     done_on_last && (i == n - 1));
    end
  endtask

  task automatic read_line(string name, logic [7:0] addr, logic [63:0] exp, logic done);
    rd_en   = 1'b1;
    rd_addr = addr;
    rd_done = done;
    exp_q.push_back(exp);
    tick();
    rd_en   = 1'b0;
    rd_done = 1'b0;
    check_output(name, rd_data, exp_q.pop_front());
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset      = 1'b1;
    in_sos     = 1'b0;
    in_eos     = 1'b0;
    in_A       = '0;
    in_FV_data = '0;
    rd_en      = 1'b0;
    rd_addr    = '0;
    rd_done    = 1'b0;

    vecs[0] = '{8'd5,  beat_data(1, 5)};
    vecs[1] = '{8'd0,  beat_data(1, 0)};
    vecs[2] = '{8'd15, beat_data(1, 15)};
    vecs[3] = '{8'd7,  beat_data(1, 7)};
    vecs[4] = '{8'd3,  beat_data(1, 3)};
    vecs[5] = '{8'd10, beat_data(1, 10)};

    #1;
    check_output("rst_rx_ready", rx_ready, 1);
    check_output("rst_buf_valid", buf_valid, 0);
    check_output("rst_buf_lines", buf_lines, 0);
    check_output("rst_rd_data", rd_data, 0);
    check_output("rst_errs", {ovf_err, proto_err}, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // T1: 16-beat stream into half 0
    send_beats(0, 15, 1, 1, 0, 0);
    check_output("t1_valid_before_eos", buf_valid, 0);
    check_output("t1_rx_ready_recv", rx_ready, 0);
    apply_stimulus(1'b0, 1'b1, 10'd15, beat_data(1, 15), 1'b0);
    check_output("t1_buf_valid", buf_valid, 1);
    check_output("t1_buf_lines", buf_lines, 16);
    check_output("t1_rx_ready", rx_ready, 1);
    for (int k = 0; k < 6; k++)
      read_line($sformatf("t1_read_%0d", vecs[k].addr), vecs[k].addr, vecs[k].data, 1'b0);
    apply_stimulus(1'b0, 1'b0, 10'd0, 64'd0, 1'b1);
    check_output("t1_released", buf_valid, 0);
    read_line("t1_hold_when_invalid", 8'd5, vecs[5].data, 1'b0);

    // T3: single-beat stream into half 1
    apply_stimulus(1'b1, 1'b1, 10'd7, 64'hABCD, 1'b0);
    check_output("t3_buf_valid", buf_valid, 1);
    check_output("t3_buf_lines", buf_lines, 1);
    read_line("t3_read", 8'd7, 64'hABCD, 1'b0);
    read_line("t3_read_with_done", 8'd7, 64'hABCD, 1'b1);
    check_output("t3_released", buf_valid, 0);

    // T2: fill both halves, then overflow
    send_beats(8'h10, 8, 2, 1, 1, 0);
    send_beats(8'h20, 8, 3, 1, 1, 0);
    check_output("t2_both_full_ready", rx_ready, 0);
    check_output("t2_buf_lines", buf_lines, 8);
    check_output("t2_no_ovf_yet", ovf_err, 0);
    send_beats(8'h10, 4, 4, 1, 1, 0);
    check_output("t2_ovf_err", ovf_err, 1);
    check_output("t2_ready_still_0", rx_ready, 0);
    read_line("t2_not_overwritten", 8'h13, beat_data(2, 3), 1'b0);
    apply_stimulus(1'b0, 1'b0, 10'd0, 64'd0, 1'b1);
    check_output("t2_ready_after_done", rx_ready, 1);
    check_output("t2_half1_lines", buf_lines, 8);
    read_line("t2_half1_read", 8'h22, beat_data(3, 2), 1'b0);

    // T4: restart mid-stream into half 0 while half 1 is still held
    check_output("t4_no_proto_yet", proto_err, 0);
    send_beats(8'h40, 3, 5, 1, 0, 0);
    send_beats(8'h40, 4, 6, 1, 1, 0);
    check_output("t4_proto_err", proto_err, 1);
    apply_stimulus(1'b0, 1'b0, 10'd0, 64'd0, 1'b1);
    check_output("t4_buf_lines", buf_lines, 4);
    read_line("t4_read_41", 8'h41, beat_data(6, 1), 1'b0);
    read_line("t4_read_42", 8'h42, beat_data(6, 2), 1'b0);

    // T5: eos on half 1 coincides with rd_done on half 0
    send_beats(8'h50, 5, 7, 1, 1, 1);
    check_output("t5_buf_valid", buf_valid, 1);
    check_output("t5_buf_lines", buf_lines, 5);
    check_output("t5_rx_ready", rx_ready, 1);
    read_line("t5_read", 8'h52, beat_data(7, 2), 1'b0);
    apply_stimulus(1'b0, 1'b1, 10'd3, 64'd1, 1'b0);
    check_output("eos_alone_lines", buf_lines, 5);
    check_output("eos_alone_ready", rx_ready, 1);

    // T6: asynchronous reset mid-stream
    apply_stimulus(1'b0, 1'b0, 10'd0, 64'd0, 1'b1);
    send_beats(8'h60, 3, 8, 1, 0, 0);
    check_output("t6_in_recv", rx_ready, 0);
    #3;
    reset = 1'b1;
    #1;
    check_output("t6_rst_rx_ready", rx_ready, 1);
    check_output("t6_rst_buf_valid", buf_valid, 0);
    check_output("t6_rst_buf_lines", buf_lines, 0);
    check_output("t6_rst_rd_data", rd_data, 0);
    check_output("t6_rst_errs", {ovf_err, proto_err}, 0);
    #2;
    reset = 1'b0;
    tick();
    send_beats(8'h60, 4, 9, 0, 1, 0);
    check_output("t6_no_sos_valid", buf_valid, 0);
    check_output("t6_no_sos_lines", buf_lines, 0);
    check_output("t6_no_sos_ready", rx_ready, 1);
    send_beats(8'h70, 2, 10, 1, 1, 0);
    check_output("t6_fresh_lines", buf_lines, 2);
    read_line("t6_fresh_read", 8'h71, beat_data(10, 1), 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
